// File: rtl/stg2if_if.sv
// Fetch-stage handshake bundle: address-stage beat and decode controls in,
// registered instruction/PC and the PC-hold stall out.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

interface stg2if_if #(
    parameter int ADDR_W = `SIZE_ADDR,
    parameter int INSN_W = `SIZE_DATA
);
    logic [INSN_W-1:0] iw_mem_data;
    logic [ADDR_W-1:0] iw_pc;
    logic              iw_ia_valid;
    logic              iw_stall;
    logic              iw_flush;
    logic [INSN_W-1:0] ow_instr;
    logic [ADDR_W-1:0] ow_pc;
    logic              ow_if_valid;
    logic              ow_stall;

    modport master (
        output iw_mem_data, iw_pc, iw_ia_valid, iw_stall, iw_flush,
        input  ow_instr, ow_pc, ow_if_valid, ow_stall
    );

    modport slave (
        input  iw_mem_data, iw_pc, iw_ia_valid, iw_stall, iw_flush,
        output ow_instr, ow_pc, ow_if_valid, ow_stall
    );
endinterface

// File: rtl/stg2if.sv
// Instruction-fetch stage: output register plus one-entry skid, with a kill
// flag that drops the beat following any stall or flush.
module stg2if #(
    parameter int ADDR_W = `SIZE_ADDR,
    parameter int INSN_W = `SIZE_DATA
) (
    input  logic      iw_clk,
    input  logic      iw_rst,
    stg2if_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_e;

    cnt_e              state, state_n;
    logic              r_kill;
    logic [INSN_W-1:0] out_instr, skid_instr;
    logic [ADDR_W-1:0] out_pc, skid_pc;
    logic              enq, deq;
    logic              load_out, load_skid, move_skid;

    assign bus.ow_if_valid = (state != EMPTY);
    assign bus.ow_stall    = (state == FULL) | ((state != EMPTY) & bus.iw_stall);
    assign bus.ow_instr    = out_instr;
    assign bus.ow_pc       = out_pc;

    // A beat one cycle after stall/flush belongs to a held or old-path address.
    assign enq = bus.iw_ia_valid & ~r_kill & ~bus.iw_flush;
    assign deq = bus.ow_if_valid & ~bus.iw_stall;

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state  <= EMPTY;
            r_kill <= 1'b0;
        end else begin
            state  <= state_n;
            r_kill <= bus.iw_flush | bus.ow_stall;
        end
    end

    always_comb begin
        state_n   = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (bus.iw_flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: if (enq) begin
                    load_out = 1'b1;
                    state_n  = ONE;
                end
                ONE: begin
                    if (enq && deq) begin
                        load_out = 1'b1;
                    end else if (enq) begin
                        load_skid = 1'b1;
                        state_n   = FULL;
                    end else if (deq) begin
                        state_n = EMPTY;
                    end
                end
                FULL: if (deq) begin
                    move_skid = 1'b1;
                    state_n   = ONE;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            out_instr  <= '0;
            out_pc     <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            if (load_out) begin
                out_instr <= bus.iw_mem_data;
                out_pc    <= bus.iw_pc;
            end else if (move_skid) begin
                out_instr <= skid_instr;
                out_pc    <= skid_pc;
            end
            if (load_skid) begin
                skid_instr <= bus.iw_mem_data;
                skid_pc    <= bus.iw_pc;
            end
        end
    end
endmodule

// File: tb/tb_stg2if.sv
// Directed bench for stg2if: free-run, stall/skid, steady streaming, flush,
// flush+stall, and asynchronous reset while full.
module tb_stg2if;
    localparam int ADDR_W = 32;
    localparam int INSN_W = 32;

    logic iw_clk = 1'b0;
    logic iw_rst = 1'b1;
    int   n_chk  = 0;
    int   n_err  = 0;

    stg2if_if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) bus ();
    stg2if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) dut (
        .iw_clk (iw_clk),
        .iw_rst (iw_rst),
        .bus    (bus)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A full stage plus a new enqueue would overwrite the skid entry.
    always @(negedge iw_clk)
        if (!iw_rst && dut.state == 2'd2 && bus.iw_ia_valid && !dut.r_kill && !bus.iw_flush)
            chk("full_enq", 64'd1, 64'd0);

    // Drive one cycle of inputs, check the combinational stall, then advance.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] d,
                       input logic st, input logic fl, input logic exp_stall, input string tag);
        bus.iw_ia_valid = v;
        bus.iw_pc       = pc;
        bus.iw_mem_data = d;
        bus.iw_stall    = st;
        bus.iw_flush    = fl;
        #1;
        chk({tag, ".stall"}, 64'(bus.ow_stall), 64'(exp_stall));
        @(posedge iw_clk);
        #1;
    endtask

    task automatic expo(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] d);
        chk({tag, ".valid"}, 64'(bus.ow_if_valid), 64'(v));
        if (v) begin
            chk({tag, ".pc"}, 64'(bus.ow_pc), 64'(pc));
            chk({tag, ".instr"}, 64'(bus.ow_instr), 64'(d));
        end
    endtask

    initial begin
        bus.iw_ia_valid = 1'b0;
        bus.iw_pc       = '0;
        bus.iw_mem_data = '0;
        bus.iw_stall    = 1'b0;
        bus.iw_flush    = 1'b0;
        repeat (2) @(posedge iw_clk);
        #1;
        chk("rst.valid", 64'(bus.ow_if_valid), 64'd0);
        chk("rst.pc",    64'(bus.ow_pc),       64'd0);
        chk("rst.instr", 64'(bus.ow_instr),    64'd0);
        chk("rst.stall", 64'(bus.ow_stall),    64'd0);
        iw_rst = 1'b0;

        // free-run
        cyc(1, 32'h000, 32'hA0, 0, 0, 0, "fr0"); expo("fr0", 1, 32'h000, 32'hA0);
        cyc(1, 32'h001, 32'hA1, 0, 0, 0, "fr1"); expo("fr1", 1, 32'h001, 32'hA1);
        cyc(1, 32'h002, 32'hA2, 0, 0, 0, "fr2"); expo("fr2", 1, 32'h002, 32'hA2);
        cyc(0, 32'h0,   32'h0,  0, 0, 0, "fr3"); expo("fr3", 0, 32'h0, 32'h0);

        // stall with skid capture
        cyc(1, 32'h010, 32'hB0, 0, 0, 0, "st0"); expo("st0", 1, 32'h010, 32'hB0);
        cyc(1, 32'h011, 32'hB1, 1, 0, 1, "st1"); expo("st1", 1, 32'h010, 32'hB0);
        cyc(1, 32'h012, 32'hB2, 1, 0, 1, "st2"); expo("st2", 1, 32'h010, 32'hB0);
        cyc(1, 32'h012, 32'hB2, 1, 0, 1, "st3"); expo("st3", 1, 32'h010, 32'hB0);
        cyc(1, 32'h012, 32'hB2, 0, 0, 1, "st4"); expo("st4", 1, 32'h011, 32'hB1);
        cyc(1, 32'h012, 32'hB2, 0, 0, 0, "st5"); expo("st5", 0, 32'h0, 32'h0);
        cyc(1, 32'h012, 32'hB2, 0, 0, 0, "st6"); expo("st6", 1, 32'h012, 32'hB2);
        cyc(0, 32'h0,   32'h0,  0, 0, 0, "st7"); expo("st7", 0, 32'h0, 32'h0);

        // steady enq+deq at count 1
        cyc(1, 32'h030, 32'hC30, 0, 0, 0, "ss0"); expo("ss0", 1, 32'h030, 32'hC30);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 32'h030 + 32'(i), 32'hC30 + 32'(i), 0, 0, 0, "ss");
            expo("ss", 1, 32'h030 + 32'(i), 32'hC30 + 32'(i));
        end
        cyc(0, 32'h0, 32'h0, 0, 0, 0, "ss9"); expo("ss9", 0, 32'h0, 32'h0);

        // flush while full
        cyc(1, 32'h020, 32'hD0, 0, 0, 0, "fl0"); expo("fl0", 1, 32'h020, 32'hD0);
        cyc(1, 32'h021, 32'hD1, 1, 0, 1, "fl1"); expo("fl1", 1, 32'h020, 32'hD0);
        cyc(1, 32'h022, 32'hD2, 0, 1, 1, "fl2"); expo("fl2", 0, 32'h0, 32'h0);
        cyc(1, 32'h023, 32'hD3, 0, 0, 0, "fl3"); expo("fl3", 0, 32'h0, 32'h0);
        cyc(1, 32'h100, 32'hE0, 0, 0, 0, "fl4"); expo("fl4", 1, 32'h100, 32'hE0);
        cyc(0, 32'h0,   32'h0,  0, 0, 0, "fl5"); expo("fl5", 0, 32'h0, 32'h0);

        // flush and stall together
        cyc(1, 32'h040, 32'hF0, 0, 0, 0, "fs0"); expo("fs0", 1, 32'h040, 32'hF0);
        cyc(1, 32'h041, 32'hF1, 1, 1, 1, "fs1"); expo("fs1", 0, 32'h0, 32'h0);
        cyc(1, 32'h042, 32'hF2, 1, 0, 0, "fs2"); expo("fs2", 0, 32'h0, 32'h0);
        cyc(1, 32'h043, 32'hF3, 0, 0, 0, "fs3"); expo("fs3", 1, 32'h043, 32'hF3);
        cyc(0, 32'h0,   32'h0,  0, 0, 0, "fs4"); expo("fs4", 0, 32'h0, 32'h0);

        // async reset while full
        cyc(1, 32'h050, 32'h150, 0, 0, 0, "ar0"); expo("ar0", 1, 32'h050, 32'h150);
        cyc(1, 32'h051, 32'h151, 1, 0, 1, "ar1"); expo("ar1", 1, 32'h050, 32'h150);
        bus.iw_ia_valid = 1'b0;
        #2 iw_rst = 1'b1;
        #1;
        chk("ar.valid", 64'(bus.ow_if_valid), 64'd0);
        chk("ar.pc",    64'(bus.ow_pc),       64'd0);
        chk("ar.instr", 64'(bus.ow_instr),    64'd0);
        chk("ar.stall", 64'(bus.ow_stall),    64'd0);
        #1 iw_rst = 1'b0;
        @(posedge iw_clk);
        #1;
        cyc(1, 32'h060, 32'h160, 0, 0, 0, "ar2"); expo("ar2", 1, 32'h060, 32'h160);
        cyc(0, 32'h0,   32'h0,   0, 0, 0, "ar3"); expo("ar3", 0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
